// File: rtl/imm_field_buffer.sv
// Two-entry (or four-entry) instruction buffer ahead of the 8-to-16 zero extender.
// Splits the oldest buffered word into opcode / rd / imm8 fields for decode.
module imm_field_buffer #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned IW    = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [IW-1:0]              instr_in,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  output logic [3:0]                 opcode_out,
  output logic [3:0]                 rd_out,
  output logic [7:0]                 bit8_out,
  output logic                       imm_valid,
  input  logic                       imm_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [IW-1:0] mem [DEPTH];
  logic [PW-1:0] wp;
  logic [PW-1:0] rp;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // Handshake depends only on occupancy and flush, never on imm_ready.
  always_comb begin
    instr_ready = (count < DEPTH_C) && !flush;
    imm_valid   = (count != '0);
    push        = instr_valid && instr_ready;
    pop         = imm_valid && imm_ready;
  end

  // Pointers and occupancy; flush outranks any push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (flush) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + PW'(1);
      if (pop)  rp <= rp + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push) mem[wp] <= instr_in;
  end

  // Head decode, zeroed while empty so the extender sees a clean input.
  always_comb begin
    head       = imm_valid ? mem[rp] : '0;
    opcode_out = head[15:12];
    rd_out     = head[11:8];
    bit8_out   = head[7:0];
  end

endmodule

// File: tb/tb_imm_field_buffer.sv
// Bench for imm_field_buffer: queue-based reference model checked every cycle,
// plus directed literal expectations for each scenario.
module tb_imm_field_buffer;

  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [15:0] instr_in;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  opcode_out;
  logic [3:0]  rd_out;
  logic [7:0]  bit8_out;
  logic        imm_valid;
  logic        imm_ready;
  logic [1:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] model_q [$];

  imm_field_buffer #(.DEPTH(DEPTH), .IW(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .instr_in(instr_in),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .opcode_out(opcode_out), .rd_out(rd_out), .bit8_out(bit8_out),
    .imm_valid(imm_valid), .imm_ready(imm_ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a FIFO queue; flush and reset simply empty it.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_q.delete();
    end else if (flush) begin
      model_q.delete();
    end else begin
      logic do_push;
      logic do_pop;
      do_push = instr_valid && (model_q.size() < DEPTH);
      do_pop  = imm_ready && (model_q.size() != 0);
      if (do_pop)  void'(model_q.pop_front());
      if (do_push) model_q.push_back(instr_in);
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [15:0] h;
    h = (model_q.size() != 0) ? model_q[0] : 16'h0000;
    chk("m_count", 32'(count), 32'(model_q.size()));
    chk("m_instr_ready", 32'(instr_ready), 32'((model_q.size() < DEPTH) && !flush));
    chk("m_imm_valid", 32'(imm_valid), 32'(model_q.size() != 0));
    chk("m_opcode", 32'(opcode_out), 32'(h[15:12]));
    chk("m_rd", 32'(rd_out), 32'(h[11:8]));
    chk("m_bit8", 32'(bit8_out), 32'(h[7:0]));
  end

  // One edge with the given inputs; returns 1 time unit after the edge.
  task automatic cyc(input logic v, input logic [15:0] d, input logic r, input logic f);
    instr_valid = v;
    instr_in    = d;
    imm_ready   = r;
    flush       = f;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] zext;
    rst_n       = 1'b0;
    flush       = 1'b0;
    instr_valid = 1'b1;
    instr_in    = 16'hDEAD;
    imm_ready   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    // Reset values with a valid word offered
    chk("rst_ready", 32'(instr_ready), 32'h1);
    chk("rst_valid", 32'(imm_valid), 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_bit8", 32'(bit8_out), 32'h00);
    instr_valid = 1'b0;
    rst_n       = 1'b1;
    cyc(0, 16'h0000, 0, 0);
    chk("rst_nocapture", 32'(count), 32'h0);

    // Single word, then stall
    cyc(1, 16'h3A1B, 0, 0);
    chk("single_valid", 32'(imm_valid), 32'h1);
    chk("single_opcode", 32'(opcode_out), 32'h3);
    chk("single_rd", 32'(rd_out), 32'hA);
    chk("single_bit8", 32'(bit8_out), 32'h1B);
    zext = {8'h00, bit8_out};
    chk("single_zext", 32'(zext), 32'h001B);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 16'h0000, 0, 0);
      chk("stall_bit8", 32'(bit8_out), 32'h1B);
    end
    cyc(0, 16'h0000, 1, 0);
    chk("single_drained", 32'(count), 32'h0);

    // Fill to full, then pop with valid held
    cyc(1, 16'h1103, 0, 0);
    cyc(1, 16'h22FF, 0, 0);
    chk("full_count", 32'(count), 32'h2);
    chk("full_ready", 32'(instr_ready), 32'h0);
    chk("full_head", 32'(bit8_out), 32'h03);
    cyc(1, 16'h3333, 1, 0);
    chk("after_pop_count", 32'(count), 32'h1);
    chk("after_pop_ready", 32'(instr_ready), 32'h1);
    chk("after_pop_head", 32'(bit8_out), 32'hFF);
    cyc(0, 16'h0000, 1, 0);
    chk("fill_drained", 32'(count), 32'h0);

    // Simultaneous push and pop, then a back-to-back stream across the wrap
    cyc(1, 16'h1111, 0, 0);
    cyc(1, 16'h4505, 1, 0);
    chk("pp_count", 32'(count), 32'h1);
    chk("pp_bit8", 32'(bit8_out), 32'h05);
    for (int i = 0; i < 8; i++) begin
      cyc(1, {4'h5, 4'(i), 8'(i * 17)}, 1, 0);
    end
    chk("stream_count", 32'(count), 32'h1);
    chk("stream_last", 32'(bit8_out), 32'h77);
    chk("stream_rd", 32'(rd_out), 32'h7);
    cyc(0, 16'h0000, 1, 0);

    // Flush with push and pop requested in the same cycle
    cyc(1, 16'hAAAA, 0, 0);
    cyc(1, 16'hBBBB, 0, 0);
    chk("preflush_count", 32'(count), 32'h2);
    instr_valid = 1'b1;
    instr_in    = 16'hCCCC;
    imm_ready   = 1'b1;
    flush       = 1'b1;
    #1;
    chk("flush_ready", 32'(instr_ready), 32'h0);
    @(posedge clk);
    #1;
    flush       = 1'b0;
    instr_valid = 1'b0;
    imm_ready   = 1'b0;
    #1;
    chk("flush_count", 32'(count), 32'h0);
    chk("flush_valid", 32'(imm_valid), 32'h0);
    chk("flush_bit8", 32'(bit8_out), 32'h00);
    cyc(1, 16'h7F1B, 0, 0);
    chk("postflush_opcode", 32'(opcode_out), 32'h7);
    chk("postflush_rd", 32'(rd_out), 32'hF);
    chk("postflush_bit8", 32'(bit8_out), 32'h1B);
    cyc(0, 16'h0000, 1, 0);

    // Asynchronous reset between edges
    cyc(1, 16'h1234, 0, 0);
    cyc(1, 16'h5678, 0, 0);
    instr_valid = 1'b0;
    chk("prereset_count", 32'(count), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_count", 32'(count), 32'h0);
    chk("async_valid", 32'(imm_valid), 32'h0);
    chk("async_ready", 32'(instr_ready), 32'h1);
    chk("async_bit8", 32'(bit8_out), 32'h00);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 16'h0003, 0, 0);
    chk("postreset_bit8", 32'(bit8_out), 32'h03);
    chk("postreset_count", 32'(count), 32'h1);
    cyc(0, 16'h0000, 1, 0);
    cyc(0, 16'h0000, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
